// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit for the EX stage. It executes MULT, MULTU,
// DIV and DIVU and produces the 64-bit {HI,LO} result for the HILO write path.
// The pipeline is stalled through busy while an operation is in flight.
//   - Multiply: fixed latency of MUL_CYCLES from accept to DONE.
//   - Divide  : radix-2 restoring divider, one quotient bit per cycle,
//               32 iterations, DONE 33 cycles after accept.
//   - Divide by zero: no iteration, DONE one cycle after accept with
//               HI = dividend and LO = all ones.
//
// Parameters
//   MUL_CYCLES    cycles from accept to DONE for a multiply (1..4)
//
// Ports
//   clk           in   1   clock, all state updates on the rising edge
//   rst           in   1   synchronous reset, active low
//   flush         in   1   cancel the in-flight or offered operation
//   op_valid      in   1   EX holds a mult/div instruction (held until !busy)
//   op            in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a         in   32  rs operand (dividend / multiplicand)
//   src_b         in   32  rt operand (divisor / multiplier)
//   busy          out  1   stall request to pipeline control
//   result_valid  out  1   one-cycle pulse while result holds a completed op
//   result        out  64  {HI[63:32], LO[31:0]}
// ============================================================================
module muldiv_unit #(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        op_valid,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        result_valid,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Value of cnt on the last cycle spent in MUL. Only meaningful when
   // MUL_CYCLES >= 2; a single-cycle multiply goes straight to DONE.
   localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 2);

   state_t      state;
   logic [5:0]  cnt;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] rem;
   logic [31:0] quo;

   // Operand decode for the offered instruction: signed ops are reduced to
   // magnitudes plus sign flags so multiply and divide work on unsigned data.
   logic        in_signed;
   logic        in_sign_a;
   logic        in_sign_b;
   logic [31:0] in_mag_a;
   logic [31:0] in_mag_b;

   assign in_signed = ~op[0];
   assign in_sign_a = in_signed & src_a[31];
   assign in_sign_b = in_signed & src_b[31];
   assign in_mag_a  = in_sign_a ? (32'd0 - src_a) : src_a;
   assign in_mag_b  = in_sign_b ? (32'd0 - src_b) : src_b;

   // The multiplier reads the live operands in IDLE (needed only for a
   // single-cycle multiply) and the captured operands in MUL, so one
   // multiplier serves both cases.
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_neg;
   logic [63:0] mul_mag;
   logic [63:0] mul_res;

   assign mul_a   = (state == S_IDLE) ? in_mag_a : mag_a;
   assign mul_b   = (state == S_IDLE) ? in_mag_b : mag_b;
   assign mul_neg = (state == S_IDLE) ? (in_sign_a ^ in_sign_b) : (sign_a ^ sign_b);
   assign mul_mag = 64'(mul_a) * 64'(mul_b);
   assign mul_res = mul_neg ? (64'd0 - mul_mag) : mul_mag;

   // One restoring-division step. The dividend magnitude is shifted out of
   // the top of quo while quotient bits are shifted in at the bottom, so
   // after 32 steps quo holds the quotient and rem the remainder.
   logic [32:0] rem_shift;
   logic [32:0] trial;
   logic        fits;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign rem_shift = {rem, quo[31]};
   assign trial     = rem_shift - {1'b0, mag_b};
   assign fits      = ~trial[32];
   assign rem_next  = fits ? trial[31:0] : rem_shift[31:0];
   assign quo_next  = {quo[30:0], fits};

   // Quotient truncates toward zero and carries sa^sb; the remainder takes
   // the dividend's sign. Sign flags are zero for DIVU, so this is a no-op.
   assign quo_fix = (sign_a ^ sign_b) ? (32'd0 - quo_next) : quo_next;
   assign rem_fix = sign_a ? (32'd0 - rem_next) : rem_next;

   // Stall is combinational so the pipeline holds in the accept cycle itself.
   assign busy = ((state == S_IDLE) && op_valid && !flush) ||
                 (state == S_MUL) || (state == S_DIV);

   // Main control: reset beats flush, flush beats normal sequencing.
   // result_valid is set only on the edge that enters DONE, so it is a
   // one-cycle registered pulse; a flush seen during DONE cannot retract it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         cnt          <= 6'd0;
         sign_a       <= 1'b0;
         sign_b       <= 1'b0;
         mag_a        <= 32'd0;
         mag_b        <= 32'd0;
         rem          <= 32'd0;
         quo          <= 32'd0;
         result       <= 64'd0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (op_valid) begin
                     sign_a <= in_sign_a;
                     sign_b <= in_sign_b;
                     mag_a  <= in_mag_a;
                     mag_b  <= in_mag_b;
                     cnt    <= 6'd0;
                     if (!op[1]) begin
                        if (MUL_CYCLES == 1) begin
                           result       <= mul_res;
                           result_valid <= 1'b1;
                           state        <= S_DONE;
                        end else begin
                           state <= S_MUL;
                        end
                     end else if (src_b == 32'd0) begin
                        result       <= {src_a, 32'hFFFF_FFFF};
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                     end else begin
                        rem   <= 32'd0;
                        quo   <= in_mag_a;
                        state <= S_DIV;
                     end
                  end
               end
               S_MUL: begin
                  if (cnt == MUL_LAST) begin
                     result       <= mul_res;
                     result_valid <= 1'b1;
                     cnt          <= 6'd0;
                     state        <= S_DONE;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
               S_DIV: begin
                  rem <= rem_next;
                  quo <= quo_next;
                  if (cnt == 6'd31) begin
                     result       <= {rem_fix, quo_fix};
                     result_valid <= 1'b1;
                     cnt          <= 6'd0;
                     state        <= S_DONE;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
